// File: rtl/i2c_mon_pkg.sv
// Shared types and widths for the I2C bus monitor.
// Optional glitch filter is enabled with I2C_MON_GLITCH_FILTER_EN.
package i2c_mon_pkg;

  localparam int I2C_ADDR_W    = 7;
  localparam int I2C_BYTE_W    = 8;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACK
  } mon_state_e;

  function automatic int cnt_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Bus wires, address and observer outputs of the I2C monitor.
// Shared with the monitor top (I2C_MON_GLITCH_FILTER_EN build option).
interface i2c_bus_monitor_if
  import i2c_mon_pkg::*;
#(
  parameter int MAX_BYTES = 16
);
  localparam int CNT_W = cnt_width(MAX_BYTES);

  logic                  sda;
  logic                  scl;
  logic [I2C_ADDR_W-1:0] dev_addr;
  logic                  start_pulse;
  logic                  rstart_pulse;
  logic                  stop_pulse;
  logic                  byte_valid;
  logic [I2C_BYTE_W-1:0] byte_data;
  logic                  ack_valid;
  logic                  ack;
  logic                  addr_match;
  logic                  rw;
  logic                  frame_active;
  logic [3:0]            bit_count;
  logic [CNT_W-1:0]      byte_count;
  logic                  overflow;
  logic                  bus_error;

  modport master (
    output sda, scl, dev_addr,
    input  start_pulse, rstart_pulse, stop_pulse,
    input  byte_valid, byte_data, ack_valid, ack,
    input  addr_match, rw, frame_active,
    input  bit_count, byte_count, overflow, bus_error
  );

  modport slave (
    input  sda, scl, dev_addr,
    output start_pulse, rstart_pulse, stop_pulse,
    output byte_valid, byte_data, ack_valid, ack,
    output addr_match, rw, frame_active,
    output bit_count, byte_count, overflow, bus_error
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Synchroniser, optional glitch filter and edge strobes for one bus line.
// Glitch filter present only when I2C_MON_GLITCH_FILTER_EN is defined.
module i2c_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (GLITCH_CYCLES < 1) begin : g_bad_glitch
    $error("GLITCH_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign synced = sync[SYNC_STAGES-1];

`ifdef I2C_MON_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic [GW-1:0] run;
  logic          filt;

  // Accept a new level only after GLITCH_CYCLES differing samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b1;
      run  <= '0;
    end else if (synced == filt) begin
      run  <= '0;
    end else if (run == GW'(GLITCH_CYCLES - 1)) begin
      filt <= synced;
      run  <= '0;
    end else begin
      run  <= run + GW'(1);
    end
  end

  assign level = filt;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Read-only I2C frame tracker: START/STOP, bytes, ACK, address, errors.
// Define I2C_MON_GLITCH_FILTER_EN to filter short pulses on sda/scl.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 3,
  parameter int MAX_BYTES     = 16
) (
  input logic              system_clock,
  input logic              reset_n,
  i2c_bus_monitor_if.slave bus
);

  localparam int CNT_W = cnt_width(MAX_BYTES);

  logic sda_lvl, sda_rise, sda_fall;
  logic scl_lvl, scl_rise, scl_fall;

  i2c_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_sda (
    .clk  (system_clock),
    .rst  (reset_n),
    .raw  (bus.sda),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  i2c_line_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_scl (
    .clk  (system_clock),
    .rst  (reset_n),
    .raw  (bus.scl),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  mon_state_e                  state;
  logic [BITS_PER_BYTE-2:0]    shift;
  logic                        pend;
  logic                        scl_edge;
  logic                        start_ev;
  logic                        stop_ev;
  logic                        err;
  logic [I2C_BYTE_W-1:0]       full;

  assign scl_edge = scl_rise | scl_fall;
  assign start_ev = sda_fall & scl_lvl & ~scl_edge;
  assign stop_ev  = sda_rise & scl_lvl & ~scl_edge;
  assign full     = {shift, sda_lvl};

  // The SCL rise that precedes a legal START/STOP counts bit 1 with SCL
  // still high (pend); that case is a clean frame boundary, not an error.
  assign err = (state == ACK)
             || (bit_count_gt1())
             || (bus.bit_count == 4'd1 && !pend);

  function automatic logic bit_count_gt1();
    return bus.bit_count > 4'd1;
  endfunction

  always_ff @(posedge system_clock or posedge reset_n) begin
    if (reset_n) begin
      state            <= IDLE;
      shift            <= '0;
      pend             <= 1'b0;
      bus.start_pulse  <= 1'b0;
      bus.rstart_pulse <= 1'b0;
      bus.stop_pulse   <= 1'b0;
      bus.byte_valid   <= 1'b0;
      bus.byte_data    <= '0;
      bus.ack_valid    <= 1'b0;
      bus.ack          <= 1'b0;
      bus.addr_match   <= 1'b0;
      bus.rw           <= 1'b0;
      bus.frame_active <= 1'b0;
      bus.bit_count    <= '0;
      bus.byte_count   <= '0;
      bus.overflow     <= 1'b0;
      bus.bus_error    <= 1'b0;
    end else begin
      bus.start_pulse  <= 1'b0;
      bus.rstart_pulse <= 1'b0;
      bus.stop_pulse   <= 1'b0;
      bus.byte_valid   <= 1'b0;
      bus.ack_valid    <= 1'b0;
      bus.bus_error    <= 1'b0;
      if (scl_fall) pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            bus.start_pulse  <= 1'b1;
            bus.frame_active <= 1'b1;
            bus.bit_count    <= '0;
            bus.byte_count   <= '0;
            bus.addr_match   <= 1'b0;
            bus.overflow     <= 1'b0;
            pend             <= 1'b0;
            state            <= DATA;
          end
        end
        default: begin
          if (start_ev) begin
            bus.rstart_pulse <= 1'b1;
            bus.bus_error    <= err;
            bus.bit_count    <= '0;
            bus.byte_count   <= '0;
            bus.addr_match   <= 1'b0;
            bus.overflow     <= 1'b0;
            pend             <= 1'b0;
            state            <= DATA;
          end else if (stop_ev) begin
            bus.stop_pulse   <= 1'b1;
            bus.bus_error    <= err;
            bus.frame_active <= 1'b0;
            bus.addr_match   <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.bit_count    <= '0;
            pend             <= 1'b0;
            state            <= IDLE;
          end else if (scl_rise && state == ACK) begin
            bus.ack_valid    <= 1'b1;
            bus.ack          <= ~sda_lvl;
            bus.bit_count    <= '0;
            state            <= DATA;
          end else if (scl_rise) begin
            shift         <= full[BITS_PER_BYTE-2:0];
            bus.bit_count <= bus.bit_count + 4'd1;
            if (bus.bit_count == 4'd0) pend <= 1'b1;
            if (bus.bit_count == 4'(BITS_PER_BYTE - 1)) begin
              bus.byte_valid <= 1'b1;
              bus.byte_data  <= full;
              if (bus.byte_count != CNT_W'(MAX_BYTES))
                bus.byte_count <= bus.byte_count + CNT_W'(1);
              if (bus.byte_count >= CNT_W'(MAX_BYTES - 1))
                bus.overflow <= 1'b1;
              if (bus.byte_count == '0) begin
                bus.rw         <= full[0];
                bus.addr_match <= (full[7:1] == bus.dev_addr);
              end
              state <= ACK;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Synthesisable, system-clock-domain I2C bus observer that replaces free-running SCL-edge counters with a synchronised, parametrised frame tracker.
- Detects START, repeated START and STOP, and assembles bytes MSB-first.
- Captures the ACK/NACK bit, classifies the address byte and flags protocol errors.
- Sits beside the slave memory on the sda/scl wires, read-only, feeding scoreboard taps and debug registers.

Parameters:
- SYNC_STAGES, 2, flops in each sda/scl synchroniser (min 2).
- GLITCH_CYCLES, 3, consecutive stable samples a line needs before a change is accepted (filter build only).
- MAX_BYTES, 16, frame byte-counter saturation value; counter width CNT_W = $clog2(MAX_BYTES+1).

Ports:
- system_clock  input  1  sampling clock, at least 8x SCL rate.
- reset_n  input  1  asynchronous, active-high reset; asserted when 1 despite the suffix.
- sda  input  1  raw bus SDA (resolved wire).
- scl  input  1  raw bus SCL.
- dev_addr  input  7  address compared against the first byte of each frame.
- start_pulse  output  1  one-cycle pulse on START from idle.
- rstart_pulse  output  1  one-cycle pulse on repeated START.
- stop_pulse  output  1  one-cycle pulse on STOP.
- byte_valid  output  1  one-cycle pulse; byte_data is valid.
- byte_data  output  8  last assembled byte.
- ack_valid  output  1  one-cycle pulse; ack is valid.
- ack  output  1  1 = ACK (SDA low on the 9th bit).
- addr_match  output  1  high from the end of the address byte until STOP/START when byte[7:1] == dev_addr.
- rw  output  1  bit 0 of the address byte.
- frame_active  output  1  high from START to STOP.
- bit_count  output  4  0..8 position within the current byte.
- byte_count  output  CNT_W  bytes since the last (repeated) START, saturating.
- overflow  output  1  sticky once byte_count saturates; cleared by START or STOP.
- bus_error  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: every output is 0; the FSM is in IDLE; synchroniser flops reset to 1 (bus idle high).
- Synchronisation:
  - sda and scl each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised (or filtered) copies.
  - Latency from a raw edge to the resulting pulse is SYNC_STAGES+1 cycles.
- Events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bit: sampled on an SCL rising edge while frame_active is high.
  - If an SDA edge and an SCL edge fall in the same cycle, the SCL edge is processed; the SDA edge is ignored.
- FSM IDLE:
  - START -> DATA; start_pulse, frame_active=1, bit_count=0, byte_count=0.
  - SCL edges are ignored.
  - STOP -> stay in IDLE, no pulse.
- FSM DATA (bit_count 0..7):
  - Each SCL rise shifts SDA into the shift register and increments bit_count.
  - On the 8th rise: byte_valid pulse, byte_data updated, byte_count++ (saturates at MAX_BYTES and sets overflow), -> ACK.
  - If byte_count was 0 at that point: latch rw = bit 0 and addr_match = (byte[7:1] == dev_addr).
- FSM ACK:
  - Next SCL rise: ack_valid pulse, ack = ~SDA, bit_count=0, -> DATA.
- START while frame_active:
  - rstart_pulse; byte_count, bit_count, addr_match and overflow clear; -> DATA.
- STOP while frame_active:
  - stop_pulse; frame_active, addr_match and overflow clear; bit_count=0; -> IDLE.
- Errors:
  - START or STOP with bit_count in 1..7, or during ACK before its SCL rise, also pulses bus_error in the same cycle as the start/rstart/stop pulse.
  - The partial byte is discarded: no byte_valid.
- Reset mid-frame: immediate return to the reset state; the monitor waits for the next START (it does not resynchronise mid-byte).
- byte_data and rw hold their last values between pulses.

Optional Feature:
- Macro I2C_MON_GLITCH_FILTER_EN.
- When defined:
  - Each synchronised line feeds a counter filter.
  - The output changes only after GLITCH_CYCLES consecutive samples differ from the current value.
  - Pulses shorter than GLITCH_CYCLES cycles are suppressed.
  - Latency becomes SYNC_STAGES+GLITCH_CYCLES+1.
- When undefined: the synchronised lines are used directly and GLITCH_CYCLES is unused.

Decomposition:
- Package i2c_mon_pkg:
  - typedef enum {IDLE, DATA, ACK} mon_state_e.
  - I2C_ADDR_W=7, I2C_BYTE_W=8, BITS_PER_BYTE=8.
- Sub-module i2c_line_filter, one instance per line: synchroniser plus optional glitch filter, outputs filtered level and rise/fall strobes.

Test Plan:
- Write to 0x50 (dev_addr=0x50), START, bytes 0xA0, 0x12, 0x34 all ACKed, STOP:
  - start_pulse; byte_valid x3 with 0xA0, 0x12, 0x34; ack=1 x3.
  - addr_match=1, rw=0, byte_count=3, then stop_pulse and frame_active=0.
- Read with NACK: address byte 0xA1, then 0x5A NACKed:
  - rw=1; second ack_valid carries ack=0.
- Repeated START: after 0xA0, 0x00, issue repeated START then 0xA1:
  - rstart_pulse; byte_count goes 2->0->1; no bus_error.
- Mid-byte STOP after 4 bits:
  - stop_pulse and bus_error in the same cycle; no byte_valid; FSM in IDLE.
- Address mismatch: dev_addr=0x3C, send 0xA0:
  - addr_match=0; byte_valid still fires with 0xA0.
- I2C_MON_GLITCH_FILTER_EN with GLITCH_CYCLES=3: inject a 2-cycle SCL high pulse mid-bit:
  - no bit counted, bit_count unchanged.
  - Without the macro, the same pulse increments bit_count.
